// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the combinational ROM and queues
// {pc, instr} pairs in a 2-entry buffer that decode drains over valid/ready.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    localparam logic [1:0]  FULL    = 2'(DEPTH);
    localparam logic [64:0] MEM_LIM = 65'(MEM_SIZE);

    state_t      state, state_nxt;
    logic [63:0] pc;
    logic [1:0]  count, count_nxt;
    logic        head, head_nxt;
    logic        tail;
    logic [63:0] buf_pc    [2];
    logic [31:0] buf_instr [2];

    logic run, pop, bad, fetch, take_redirect, take_fault;

    assign imem_addr = pc;
    assign run       = (state == S_RUN);
    assign pop       = out_valid & out_ready;

    // Bounds check done one bit wider so pc+3 cannot wrap past the limit.
    assign bad = (pc[1:0] != 2'b00) | (({1'b0, pc} + 65'd3) >= MEM_LIM);

    assign take_redirect = run & redirect_valid;
    assign take_fault    = run & ~redirect_valid & bad & fetch_en;
    assign fetch         = run & fetch_en & ~redirect_valid & ~bad & ((count < FULL) | pop);

    // With a full buffer and a pop, the freed head slot is the write slot.
    assign tail = head ^ count[0];

    assign out_instr = buf_instr[head];
    assign out_pc    = buf_pc[head];

    // ---- control: state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        head_nxt  = head;
        if (take_fault) begin
            state_nxt = S_FAULT;
        end
        if (take_redirect) begin
            count_nxt = 2'd0;
            head_nxt  = 1'b0;
        end else begin
            count_nxt = count + {1'b0, fetch} - {1'b0, pop};
            if (pop) begin
                head_nxt = ~head;
            end
        end
    end

    // ---- control: pc, occupancy, fault capture ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            count     <= 2'd0;
            head      <= 1'b0;
            out_valid <= 1'b0;
            fault     <= 1'b0;
            fault_pc  <= 64'd0;
        end else begin
            count     <= count_nxt;
            head      <= head_nxt;
            out_valid <= (count_nxt != 2'd0);
            if (take_redirect) begin
                pc <= redirect_pc;
            end else if (fetch) begin
                pc <= pc + 64'd4;
            end
            if (take_fault) begin
                fault    <= 1'b1;
                fault_pc <= pc;
            end
        end
    end

    // ---- data: fetch buffer storage ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]    <= 64'd0;
                buf_instr[i] <= 32'd0;
            end
        end else if (fetch) begin
            buf_pc[tail]    <= pc;
            buf_instr[tail] <= imem_instr;
        end
    end

endmodule
